// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg : shared state encoding, error codes and address helpers for the
//            data-memory responder.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    localparam int unsigned C_WORD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

    // Compares the full word index so nonzero upper bits never alias into the array.
    function automatic logic [1:0] addr_check(input logic [31:0] addr,
                                              input int unsigned depth);
        logic [1:0] e;
        e = ERR_NONE;
        if (addr[1:0] != 2'b00) begin
            e = e | ERR_MISALIGN;
        end
        if ({2'b00, word_index(addr)} >= 32'(depth)) begin
            e = e | ERR_RANGE;
        end
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array : single-port synchronous word RAM with registered read data.
//              Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read data only moves on a load, so it stays stable while a response waits.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder : valid/ready data-memory target with configurable wait
//                  states in front of a word array.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              rsel_q;

    logic              w_accept;
    logic              w_access;
    logic              w_resp_done;
    logic              w_acc_write;
    logic [31:0]       w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic [1:0]        w_err_code;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_arr_rdata;

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign w_accept     = req_ready_o & req_valid_i;
    assign w_resp_done  = resp_valid_o & resp_ready_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY == 0) begin
                        w_access = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    w_access = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the access happens on the accept edge itself,
    // so it must use the live request rather than the captured copy.
    assign w_acc_write = (state_q == ST_IDLE) ? req_write_i : wr_q;
    assign w_acc_addr  = (state_q == ST_IDLE) ? req_addr_i  : addr_q;
    assign w_acc_wdata = (state_q == ST_IDLE) ? req_wdata_i : wdata_q;

    assign w_err_code = addr_check(w_acc_addr, DEPTH);
    assign w_err      = (w_err_code != ERR_NONE);
    assign w_idx      = IDX_W'(word_index(w_acc_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
        end else if (w_accept) begin
            wr_q    <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end
    end

    // rsel_q marks a successful load; everything else reports zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            rsel_q <= 1'b0;
        end else if (w_access) begin
            err_q  <= w_err;
            rsel_q <= ~w_acc_write & ~w_err;
        end else if (w_resp_done) begin
            err_q  <= 1'b0;
            rsel_q <= 1'b0;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .en_i    (w_access & ~w_err),
        .we_i    (w_acc_write),
        .idx_i   (w_idx),
        .wdata_i (w_acc_wdata),
        .rdata_o (w_arr_rdata)
    );

    assign resp_rdata_o = rsel_q ? w_arr_rdata : '0;
    assign resp_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder : directed bench for a LATENCY=2 and a LATENCY=0 responder.
//                     Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_ready = 1'b1;

    logic        a_req_ready, a_resp_valid, a_resp_err;
    logic [31:0] a_resp_rdata;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;

    logic        o_req_ready, o_resp_valid, o_resp_err;
    logic [31:0] o_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A), .DATA_W(32)) u_dut_l2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid & ~sel),
        .req_ready_o  (a_req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (a_resp_valid),
        .resp_ready_i (resp_ready & ~sel),
        .resp_rdata_o (a_resp_rdata),
        .resp_err_o   (a_resp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .DATA_W(32)) u_dut_l0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid & sel),
        .req_ready_o  (b_req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (b_resp_valid),
        .resp_ready_i (resp_ready & sel),
        .resp_rdata_o (b_resp_rdata),
        .resp_err_o   (b_resp_err)
    );

    assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign o_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;
    assign o_resp_err   = sel ? b_resp_err   : a_resp_err;

    // One full transaction with resp_ready high; lat counts negedges after accept.
    task automatic do_req(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_err, input string name);
        int n;
        @(negedge clk);
        req_write = w; req_addr = addr; req_wdata = wdata; req_valid = 1'b1; resp_ready = 1'b1;
        n_checks++;
        if (o_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s req_ready: got %b want 1", name, o_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        n = 0;
        while (o_resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        end
        n_checks++;
        if (o_resp_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL %s rdata: got %h want %h", name, o_resp_rdata, exp_rdata);
        end
        n_checks++;
        if (o_resp_err !== exp_err) begin
            n_fail++; $display("FAIL %s err: got %b want %b", name, o_resp_err, exp_err);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                     o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, LAT_A, 32'd0, 1'b0, "store_10");
        do_req(1'b0, 32'h10, 32'h0, LAT_A, 32'hDEAD_BEEF, 1'b0, "load_10");
        do_req(1'b1, 32'h20, 32'h1111_1111, LAT_A, 32'd0, 1'b0, "store_20");
    endtask

    task automatic test_errors();
        do_req(1'b0, 32'h13, 32'h0, LAT_A, 32'd0, 1'b1, "load_misaligned");
        do_req(1'b0, 32'(4 * DEPTH), 32'h0, LAT_A, 32'd0, 1'b1, "load_out_of_range");
        do_req(1'b1, 32'h8000_0010, 32'h5555_5555, LAT_A, 32'd0, 1'b1, "store_high_alias");
        do_req(1'b1, 32'h12, 32'h6666_6666, LAT_A, 32'd0, 1'b1, "store_misaligned");
        do_req(1'b0, 32'h10, 32'h0, LAT_A, 32'hDEAD_BEEF, 1'b0, "load_10_intact");
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (o_resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({o_resp_valid, o_req_ready, o_resp_err, o_resp_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b err=%b rd=%h want 1 0 0 deadbeef",
                         i, o_resp_valid, o_req_ready, o_resp_err, o_resp_rdata);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_resp_valid, o_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b want 0 1", o_resp_valid, o_req_ready);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h2222_2222; req_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        req_valid = 1'b0;
        n_checks++;
        if ({o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_in_wait: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                     o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, LAT_A, 32'h1111_1111, 1'b0, "load_20_after_reset");
        // Reset while a load response with nonzero data is pending.
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata} !== {3'b100, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_in_resp: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                     o_req_ready, o_resp_valid, o_resp_err, o_resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
    endtask

    task automatic test_latency0();
        sel = 1'b1;
        do_req(1'b1, 32'h4, 32'h1234_5678, 0, 32'd0, 1'b0, "l0_store_4");
        do_req(1'b0, 32'h4, 32'h0, 0, 32'h1234_5678, 1'b0, "l0_load_4");
        do_req(1'b0, 32'h6, 32'h0, 0, 32'd0, 1'b1, "l0_load_misaligned");
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        v_w   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] v_a   [8] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40, 32'h40, 32'h13};
        logic [31:0] v_d   [8] = '{32'hA0A0_0001, 32'h0, 32'hB0B0_0002, 32'h0,
                                   32'h0, 32'hC0C0_0003, 32'h0, 32'h0};
        logic [31:0] e_rd  [8] = '{32'h0, 32'hA0A0_0001, 32'h0, 32'hB0B0_0002,
                                   32'hA0A0_0001, 32'h0, 32'hC0C0_0003, 32'h0};
        logic        e_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int  k = 0;
        int  rcv = 0;
        int  last = 0;
        logic rdy;
        resp_ready = 1'b1;
        for (int t = 0; t < 200 && rcv < 8; t++) begin
            @(negedge clk);
            if (o_resp_valid === 1'b1) begin
                n_checks++;
                if (o_resp_rdata !== e_rd[rcv] || o_resp_err !== e_err[rcv]) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: got rd=%h err=%b want rd=%h err=%b",
                             rcv, o_resp_rdata, o_resp_err, e_rd[rcv], e_err[rcv]);
                end
                rcv++;
            end
            if (k < 8) begin
                req_write = v_w[k]; req_addr = v_a[k]; req_wdata = v_d[k]; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            rdy = o_req_ready;
            @(posedge clk);
            if (k < 8 && rdy === 1'b1) begin
                if (k > 0) begin
                    n_checks++;
                    if (t - last != LAT_A + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, t - last, LAT_A + 2);
                    end
                end
                last = t;
                k++;
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (k != 8 || rcv != 8) begin
            n_fail++; $display("FAIL b2b_count: got accepts=%0d resps=%0d want 8 8", k, rcv);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (o_resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_extra_resp[%0d]: got vld=%b want 0", i, o_resp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_midop();
        test_latency0();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
